// File: rtl/arb_rr.sv
// ============================================================================
// Module      : arb_rr (with helpers pry2oht, oht2bin)
// Description : Round-robin arbiter with registered one-hot grant, binary
//               index and valid.  A grant is held until ack, withdrawal of
//               the granted request, or (optionally) a timeout.
//               Optional feature macro: ARB_RR_TIMEOUT_EN enables the
//               grant-hold timeout counter and the sticky err flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// Priority to one-hot: keeps only the lowest-index set bit of in.
module pry2oht #(
    parameter int WIDTH          = 16,
    parameter int SPLIT          = 4,
    parameter int IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] oht
);
    localparam int SEGS = (WIDTH + SPLIT - 1) / SPLIT;

    generate
        if (IMPLEMENTATION == 0) begin : g_seg
            logic [SEGS-1:0] seg_any;
            logic [SEGS-1:0] seg_hit;
            logic            found;
            logic            taken;
            // Two-level search: first pick the lowest non-empty segment, then
            // the lowest set bit inside that segment.
            always_comb begin
                seg_any = '0;
                for (int i = 0; i < WIDTH; i++)
                    seg_any[i/SPLIT] = seg_any[i/SPLIT] | in[i];
                seg_hit = '0;
                found   = 1'b0;
                for (int s = 0; s < SEGS; s++) begin
                    if (seg_any[s] && !found) begin
                        seg_hit[s] = 1'b1;
                        found      = 1'b1;
                    end
                end
                oht   = '0;
                taken = 1'b0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (in[i] && seg_hit[i/SPLIT] && !taken) begin
                        oht[i] = 1'b1;
                        taken  = 1'b1;
                    end
                end
            end
        end else begin : g_flat
            logic found;
            // Flat ripple search for the lowest set bit.
            always_comb begin
                oht   = '0;
                found = 1'b0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (in[i] && !found) begin
                        oht[i] = 1'b1;
                        found  = 1'b1;
                    end
                end
            end
        end
    endgenerate
endmodule

// One-hot to binary index; all-zero input yields 0.
module oht2bin #(
    parameter int WIDTH          = 16,
    parameter int SPLIT          = 4,
    parameter int IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0]         oht,
    output logic [$clog2(WIDTH)-1:0] bin
);
    localparam int BW   = $clog2(WIDTH);
    localparam int SEGS = (WIDTH + SPLIT - 1) / SPLIT;

    generate
        if (IMPLEMENTATION == 0) begin : g_seg
            logic [BW-1:0] part [SEGS];
            // Per-segment OR of indices, then OR of the segment results.
            always_comb begin
                for (int s = 0; s < SEGS; s++)
                    part[s] = '0;
                for (int i = 0; i < WIDTH; i++)
                    if (oht[i])
                        part[i/SPLIT] = part[i/SPLIT] | BW'(i);
                bin = '0;
                for (int s = 0; s < SEGS; s++)
                    bin = bin | part[s];
            end
        end else begin : g_flat
            // Single OR of the indices of every set bit.
            always_comb begin
                bin = '0;
                for (int i = 0; i < WIDTH; i++)
                    if (oht[i])
                        bin = bin | BW'(i);
            end
        end
    endgenerate
endmodule

module arb_rr #(
    parameter int WIDTH          = 16,
    parameter int SPLIT          = 4,
    parameter int IMPLEMENTATION = 0,
    parameter int TIMEOUT        = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         req,
    input  logic                     ack,
    output logic [WIDTH-1:0]         gnt,
    output logic [$clog2(WIDTH)-1:0] bin,
    output logic                     vld,
    output logic                     err
);
    localparam int BW = $clog2(WIDTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [BW-1:0]    ptr, ptr_nxt, bin_nxt;
    logic [WIDTH-1:0] gnt_nxt;
    logic [BW-1:0]    ptr_eff, shift, rot_bin, sel_bin;
    logic [WIDTH-1:0] rot_req, rot_oht, sel_oht;
    logic             any_req, rel, new_grant, timeout_hit;

    assign any_req   = |req;
    // A release (ack, withdrawal or timeout) frees the resource this cycle.
    assign rel       = (state == BUSY) && (ack || !req[bin] || timeout_hit);
    assign new_grant = any_req && ((state == IDLE) || rel);

    // Rotate so that index ptr_eff+1 lands on bit 0; on release the pointer
    // used for selection is the grant being released (same-cycle update).
    always_comb begin
        ptr_eff = rel ? bin : ptr;
        shift   = ptr_eff + 1'b1;
        rot_req = '0;
        for (int i = 0; i < WIDTH; i++)
            rot_req[i] = req[BW'(i) + shift];
    end

    pry2oht #(.WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION)) u_pry (
        .in  (rot_req),
        .oht (rot_oht)
    );

    oht2bin #(.WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION)) u_bin (
        .oht (rot_oht),
        .bin (rot_bin)
    );

    // Undo the rotation to get the absolute one-hot grant and index.
    always_comb begin
        sel_oht = '0;
        for (int i = 0; i < WIDTH; i++)
            sel_oht[BW'(i) + shift] = rot_oht[i];
        sel_bin = rot_bin + shift;
    end

    // State register: FSM state, grant, index and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            bin   <= '0;
            ptr   <= BW'(WIDTH - 1);
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            bin   <= bin_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Next-state logic: grant from IDLE, hold or re-arbitrate from BUSY.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        bin_nxt   = bin;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = BUSY;
                    gnt_nxt   = sel_oht;
                    bin_nxt   = sel_bin;
                end
            end
            default: begin
                if (rel) begin
                    ptr_nxt = bin;
                    if (any_req) begin
                        gnt_nxt = sel_oht;
                        bin_nxt = sel_bin;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                        bin_nxt   = '0;
                    end
                end
            end
        endcase
    end

    // Output logic: valid mirrors the registered BUSY state.
    always_comb begin
        vld = (state == BUSY);
    end

`ifdef ARB_RR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt;

    assign timeout_hit = (state == BUSY) && !ack && (cnt == CW'(TIMEOUT - 1));

    // Hold-time counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (new_grant || rel)
                cnt <= '0;
            else if ((state == BUSY) && !ack)
                cnt <= cnt + 1'b1;
            if (timeout_hit)
                err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

endmodule

`default_nettype wire
